// File: rtl/cpu_pkg.sv
// Shared CPU package: internal op codes (ALU and multiply/divide unit) and
// the multiply/divide sequencer states.
package cpu_pkg;

  typedef enum logic [6:0] {
    OP_NOP   = 7'd0,
    OP_MULT  = 7'd40,
    OP_MULTU = 7'd41,
    OP_DIV   = 7'd42,
    OP_DIVU  = 7'd43,
    OP_MTHI  = 7'd44,
    OP_MTLO  = 7'd45
  } opcode_internal;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_t;

  localparam int MD_WIDTH = 32;

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
// Handshake: the issuer drives start with op/a/b for one cycle; the unit
// accepts it only while busy is low and ignores it otherwise. There is no
// back-pressure beyond busy. done pulses for one cycle when a MULT*/DIV*
// result has just been written into hi/lo; hi/lo are always readable.
interface mult_div_unit_if;
  logic        start;
  logic [6:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/md_sign_fixup.sv
// Sign handling around the unsigned multiply/divide core: magnitudes on
// entry, sign restoration on exit, and the divide-by-zero result override.
module md_sign_fixup (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  output logic [31:0] a_mag_o,
  output logic [31:0] b_mag_o,
  output logic        neg_a_o,
  output logic        neg_b_o,
  input  logic        is_div_i,
  input  logic        neg_a_q_i,
  input  logic        neg_b_q_i,
  input  logic        div_zero_i,
  input  logic [63:0] acc_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // Entry: absolute values for signed ops, raw operands otherwise.
  always_comb begin
    neg_a_o = signed_i & a_i[31];
    neg_b_o = signed_i & b_i[31];
    a_mag_o = neg_a_o ? (32'd0 - a_i) : a_i;
    b_mag_o = neg_b_o ? (32'd0 - b_i) : b_i;
  end

  // Exit: quotient/product negative when signs differ, remainder follows the
  // dividend. With a zero divisor the restoring loop leaves |a| as the
  // remainder, so the signed remainder already equals the original a; only
  // the quotient needs forcing to all ones.
  always_comb begin
    if (is_div_i) begin
      lo_o = (neg_a_q_i ^ neg_b_q_i) ? (32'd0 - acc_i[31:0]) : acc_i[31:0];
      hi_o = neg_a_q_i ? (32'd0 - acc_i[63:32]) : acc_i[63:32];
      if (div_zero_i) begin
        lo_o = 32'hFFFF_FFFF;
      end
    end else begin
      {hi_o, lo_o} = (neg_a_q_i ^ neg_b_q_i) ? (64'd0 - acc_i) : acc_i;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine with the architectural HI/LO
// registers. One iteration per clock for 32 clocks, then a sign-fix cycle.
module mult_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  mult_div_unit_if.slave    md,
  output md_state_t         dbg_state_o
);

  if (WIDTH != MD_WIDTH || ITERS != WIDTH) begin : g_param_check
    $error("mult_div_unit supports only WIDTH = ITERS = 32");
  end

  md_state_t   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic        is_div_q, is_div_d, div_zero_q, div_zero_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic        op_signed;
  logic [31:0] a_mag, b_mag, fix_hi, fix_lo;
  logic        neg_a, neg_b;
  logic [32:0] mul_sum;
  logic [33:0] div_diff;

  assign op_signed = (md.op == OP_MULT) || (md.op == OP_DIV);

  md_sign_fixup u_fixup (
    .a_i        (md.a),
    .b_i        (md.b),
    .signed_i   (op_signed),
    .a_mag_o    (a_mag),
    .b_mag_o    (b_mag),
    .neg_a_o    (neg_a),
    .neg_b_o    (neg_b),
    .is_div_i   (is_div_q),
    .neg_a_q_i  (neg_a_q),
    .neg_b_q_i  (neg_b_q),
    .div_zero_i (div_zero_q),
    .acc_i      (acc_q),
    .hi_o       (fix_hi),
    .lo_o       (fix_lo)
  );

  // One iteration step: acc holds {partial product, multiplier} for MUL and
  // {partial remainder, dividend/quotient} for DIV.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_diff = {1'b0, acc_q[63:31]} - {2'b00, opnd_q};
  end

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (md.start) begin
          case (md.op)
            OP_MULT, OP_MULTU: begin
              acc_d    = {32'd0, b_mag};
              opnd_d   = a_mag;
              neg_a_d  = neg_a;
              neg_b_d  = neg_b;
              is_div_d = 1'b0;
              cnt_d    = 5'd0;
              state_d  = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              acc_d      = {32'd0, a_mag};
              opnd_d     = b_mag;
              neg_a_d    = neg_a;
              neg_b_d    = neg_b;
              is_div_d   = 1'b1;
              div_zero_d = (md.b == 32'd0);
              cnt_d      = 5'd0;
              state_d    = ST_DIV;
            end
            OP_MTHI: hi_d = md.a;
            OP_MTLO: lo_d = md.a;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITERS - 1)) state_d = ST_FIX;
      end
      ST_DIV: begin
        if (!div_diff[33]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
        else               acc_d = {acc_q[62:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITERS - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      acc_q      <= 64'd0;
      opnd_q     <= 32'd0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign md.busy     = (state_q != ST_IDLE);
  assign md.done     = done_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign dbg_state_o = state_q;

endmodule
